// File: rtl/turbo_rx_byte_pack.sv
// turbo_rx_byte_pack: packs 2-bit deinterleaver symbols LSB-first into bytes behind a FWFT byte FIFO.
// Define TURBO_RX_BYTE_PACK_FRAME_EN to add per-byte dout_sop/dout_eop block markers.
module turbo_rx_byte_pack #(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [1:0] pb_size,
    input  logic       start,
    input  logic [1:0] din,
    input  logic       din_vld,
    output logic [7:0] dout,
    output logic       dout_vld,
    input  logic       dout_rdy,
    output logic       busy,
    output logic       done,
    output logic       ovf_err,
    output logic       size_err
`ifdef TURBO_RX_BYTE_PACK_FRAME_EN
    ,
    output logic       dout_sop,
    output logic       dout_eop
`endif
);
`ifdef TURBO_RX_BYTE_PACK_FRAME_EN
    localparam int EW = 10;
`else
    localparam int EW = 8;
`endif
    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;
    state_t state_q, state_d;
    logic [10:0] len_q, len_d;
    logic [9:0] bcnt_q, bcnt_d;
    logic [1:0] ph_q, ph_d;
    logic [5:0] sh_q, sh_d;
    logic done_q, done_d, ovf_q, ovf_d, serr_q, serr_d;
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [EW-1:0] entry, head;
    logic [FIFO_AW-1:0] wptr_q, rptr_q;
    logic [FIFO_AW:0] cnt_q, cnt_d;
    logic wr_byte, wr_en, rd, full, last;
    assign full    = cnt_q[FIFO_AW];
    assign rd      = dout_vld && dout_rdy;
    assign wr_byte = state_q == COLLECT && din_vld && ph_q == 2'd3;
    // a read on the same edge frees the slot, so a write at full still fits
    assign wr_en   = wr_byte && (!full || rd);
    assign last    = {1'b0, bcnt_q} == len_q - 11'd1;
    assign cnt_d   = cnt_q + {{FIFO_AW{1'b0}}, wr_en} - {{FIFO_AW{1'b0}}, rd};
    assign head    = mem_q[rptr_q];
`ifdef TURBO_RX_BYTE_PACK_FRAME_EN
    assign entry    = {last, bcnt_q == 10'd0, din, sh_q};
    assign dout_sop = dout_vld && head[8];
    assign dout_eop = dout_vld && head[9];
`else
    assign entry    = {din, sh_q};
`endif
    assign dout_vld = |cnt_q;
    assign dout     = dout_vld ? head[7:0] : 8'd0;
    assign busy     = state_q != IDLE;
    assign done     = done_q;
    assign ovf_err  = ovf_q;
    assign size_err = serr_q;
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        bcnt_d  = bcnt_q;
        ph_d    = ph_q;
        sh_d    = sh_q;
        serr_d  = serr_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q || (wr_byte && full && !rd);
        case (state_q)
            IDLE: begin
                if (start && pb_size == 2'd3) serr_d = 1'b1;
                else if (start) begin
                    len_d   = pb_size == 2'd0 ? 11'd16 : pb_size == 2'd1 ? 11'd136 : 11'd520;
                    bcnt_d  = 10'd0;
                    ph_d    = 2'd0;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (din_vld) begin
                    ph_d = ph_q + 2'd1;
                    sh_d = {din, sh_q[5:2]};
                end
                // dropped bytes still count so block framing is preserved
                if (wr_byte) begin
                    bcnt_d = bcnt_q + 10'd1;
                    if (last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (rd && cnt_q == (FIFO_AW+1)'(1)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            len_q   <= 11'd0;
            bcnt_q  <= 10'd0;
            ph_q    <= 2'd0;
            sh_q    <= 6'd0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            serr_q  <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            bcnt_q  <= bcnt_d;
            ph_q    <= ph_d;
            sh_q    <= sh_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            serr_q  <= serr_d;
            cnt_q   <= cnt_d;
            if (wr_en) wptr_q <= wptr_q + FIFO_AW'(1);
            if (rd) rptr_q <= rptr_q + FIFO_AW'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q] <= entry;
    end
endmodule

// File: tb/tb_turbo_rx_byte_pack.sv
// tb_turbo_rx_byte_pack: scoreboard bench for the symbol-to-byte packer and its FWFT byte FIFO.
module tb_turbo_rx_byte_pack;
    localparam int DEPTH = 8;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic [1:0] pb_size = 2'd0;
    logic start = 1'b0;
    logic [1:0] din = 2'd0;
    logic din_vld = 1'b0;
    logic dout_rdy = 1'b0;
    logic [7:0] dout;
    logic dout_vld, busy, done, ovf_err, size_err;
`ifdef TURBO_RX_BYTE_PACK_FRAME_EN
    logic dout_sop, dout_eop;
`endif
    turbo_rx_byte_pack #(.FIFO_DEPTH(DEPTH), .FIFO_AW(3)) dut (
        .clk(clk), .n_rst(n_rst), .pb_size(pb_size), .start(start),
        .din(din), .din_vld(din_vld), .dout(dout), .dout_vld(dout_vld),
        .dout_rdy(dout_rdy), .busy(busy), .done(done), .ovf_err(ovf_err),
`ifdef TURBO_RX_BYTE_PACK_FRAME_EN
        .dout_sop(dout_sop), .dout_eop(dout_eop),
`endif
        .size_err(size_err)
    );
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    logic [9:0] exp_q[$];
    int total = 0, bad = 0;
    int pushed = 0, popped = 0, done_cnt = 0, last_xfer = -10, done_cyc = -10;
    bit rnd_rdy = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_rdy) dout_rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic do_start(input logic [1:0] p);
        pb_size = p;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        din_vld = 1'b0;
        start = 1'b0;
        step();
        chk("rst_dout", 32'(dout), 0);
        chk("rst_vld", 32'(dout_vld), 0);
        chk("rst_flags", {busy, done, ovf_err, size_err}, 0);
        exp_q.delete();
        pushed = 0;
        popped = 0;
        n_rst = 1'b1;
        step();
    endtask

    // Reference: symbol i lands in byte i/4 at bit 2*(i%4); bytes past the block length are
    // never produced, and a byte arriving while DEPTH bytes are outstanding is lost.
    task automatic feed(input int len, input int first, input int n, input bit rnd, input bit pace);
        logic [7:0] b;
        logic [1:0] s;
        int k, w;
        b = 8'd0;
        for (int i = first; i < first + n; i++) begin
            s = rnd ? 2'($urandom_range(0, 3)) : 2'(i % 4);
            k = i / 4;
            if (pace && i % 4 == 3 && k < len) begin
                w = 0;
                din_vld = 1'b0;
                while (pushed - popped >= DEPTH && w < 2000) begin
                    step();
                    w++;
                end
                if (w >= 2000) chk("pace_timeout", 32'(w), 0);
            end
            if (i % 4 == 0) b = 8'd0;
            b = b | (8'(s) << (2 * (i % 4)));
            if (i % 4 == 3 && k < len && pushed - popped < DEPTH) begin
                exp_q.push_back({k == len - 1, k == 0, b});
                pushed++;
            end
            din = s;
            din_vld = 1'b1;
            step();
        end
        din_vld = 1'b0;
    endtask

    task automatic wait_done(input int tgt);
        int w;
        w = 0;
        while (done_cnt < tgt && w < 5000) begin
            step();
            w++;
        end
        chk("done_timeout", 32'(w < 5000), 1);
        step();
        step();
        chk("done_once", 32'(done_cnt), 32'(tgt));
        chk("done_after_last_xfer", 32'(done_cyc), 32'(last_xfer + 1));
        chk("busy_idle", 32'(busy), 0);
        chk("queue_empty", 32'(exp_q.size()), 0);
    endtask

    initial begin
        fork
            forever begin
                logic [9:0] e, a;
                @(negedge clk);
                if (n_rst && dout_vld && dout_rdy) begin
                    if (exp_q.size() == 0) chk("unexpected_byte", 32'(dout), 32'hFFFF);
                    else begin
                        e = exp_q.pop_front();
`ifdef TURBO_RX_BYTE_PACK_FRAME_EN
                        a = {dout_eop, dout_sop, dout};
`else
                        a = {2'b00, dout};
                        e[9:8] = 2'b00;
`endif
                        chk("byte", 32'(a), 32'(e));
                    end
                    popped++;
                    last_xfer = cyc;
                end
                if (n_rst && done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    chk("busy_with_done", 32'(busy), 0);
                end
            end
        join_none
        step();
        do_reset();
        // PB16 basic
        dout_rdy = 1'b1;
        do_start(2'd0);
        chk("busy_after_start", 32'(busy), 1);
        feed(16, 0, 64, 1'b0, 1'b0);
        wait_done(1);
        chk("pb16_xfers", 32'(popped), 16);
        chk("pb16_errs", {ovf_err, size_err}, 0);
        // latency and packing
        dout_rdy = 1'b0;
        do_start(2'd0);
        din_vld = 1'b1;
        din = 2'd3;
        step();
        din = 2'd0;
        step();
        step();
        chk("lat_vld_before", 32'(dout_vld), 0);
        din = 2'd1;
        step();
        din_vld = 1'b0;
        chk("lat_vld_after", 32'(dout_vld), 1);
        chk("lat_dout", 32'(dout), 32'h43);
        do_reset();
        // backpressure and overflow
        do_start(2'd0);
        feed(16, 0, 32, 1'b0, 1'b0);
        chk("ovf_before", 32'(ovf_err), 0);
        feed(16, 32, 4, 1'b0, 1'b0);
        chk("ovf_set", 32'(ovf_err), 1);
        chk("ovf_hold_vld", 32'(dout_vld), 1);
        chk("ovf_hold_dout", 32'(dout), 32'hE4);
        feed(16, 36, 28, 1'b0, 1'b0);
        chk("ovf_drain_busy", 32'(busy), 1);
        dout_rdy = 1'b1;
        wait_done(2);
        chk("ovf_xfers", 32'(popped), 8);
        do_reset();
        // PB520 with random backpressure and extra symbols during DRAIN
        rnd_rdy = 1'b1;
        do_start(2'd2);
        feed(520, 0, 2080 + 24, 1'b1, 1'b1);
        wait_done(3);
        chk("pb520_xfers", 32'(popped), 520);
        chk("pb520_ovf", 32'(ovf_err), 0);
        // PB136 random (frame markers checked when enabled)
        do_start(2'd1);
        feed(136, 0, 544, 1'b1, 1'b1);
        wait_done(4);
        chk("pb136_xfers", 32'(popped), 520 + 136);
        rnd_rdy = 1'b0;
        // reserved size
        do_start(2'd3);
        chk("size_err", 32'(size_err), 1);
        chk("size_busy", 32'(busy), 0);
        do_reset();
        // reset mid-PB136 then PB16 again
        dout_rdy = 1'b0;
        do_start(2'd1);
        feed(136, 0, 100, 1'b1, 1'b0);
        do_reset();
        dout_rdy = 1'b1;
        do_start(2'd0);
        feed(16, 0, 64, 1'b0, 1'b0);
        wait_done(5);
        chk("restart_xfers", 32'(popped), 16);
        chk("restart_errs", {ovf_err, size_err}, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/turbo_rx_byte_pack.md
Name: turbo_rx_byte_pack

Overview:
- Downstream stage of the turbo RX deinterleaver; consumes its 2-bit serial output stream (rdata0 / dout_vld).
- Packs 2-bit symbols into bytes, LSB-first, and tracks the PHY-block length selected by pb_size.
- Buffers bytes in a small FIFO and presents them on a valid/ready byte interface to the MAC-side consumer.
- Flags overflow and length-protocol errors.

Parameters:
- FIFO_DEPTH, 8, byte FIFO entries; power of two, minimum 2.
- FIFO_AW, 3, FIFO address width; must equal log2(FIFO_DEPTH).

Ports:
- clk  input  1  system clock.
- n_rst  input  1  asynchronous active-low reset.
- pb_size  input  2  block size, sampled on start. 0=PB16 (16 B), 1=PB136 (136 B), 2=PB520 (520 B), 3=reserved.
- start  input  1  single-cycle pulse; arms the packer for one block.
- din  input  2  deinterleaved symbol, connected to the deinterleaver rdata0.
- din_vld  input  1  din qualifier, connected to the deinterleaver dout_vld.
- dout  output  8  packed byte, FIFO head.
- dout_vld  output  1  dout valid.
- dout_rdy  input  1  consumer ready; a transfer occurs when dout_vld && dout_rdy.
- busy  output  1  high in COLLECT or DRAIN.
- done  output  1  one-cycle pulse when the last byte of the block is transferred.
- ovf_err  output  1  sticky; set when a completed byte is dropped because the FIFO is full.
- size_err  output  1  sticky; set by start with pb_size=3.

Behaviour:
- Reset (async, n_rst=0): all outputs 0, FIFO empty, state IDLE, symbol and byte counters 0, sticky flags cleared.
- Block length in bytes: 16, 136 or 520, held in an 11-bit register. The byte counter is 10 bits and the symbol phase is 2 bits.
- State IDLE:
  - start with pb_size 0..2: latch the length, clear the counters, go to COLLECT.
  - start with pb_size=3: set size_err, stay in IDLE.
  - din_vld in IDLE is ignored.
- State COLLECT: each din_vld shifts din into the byte.
  - 1st symbol -> bits[1:0], 2nd -> [3:2], 3rd -> [5:4], 4th -> [7:6].
  - On the 4th symbol the byte (assembled with the current din) is written to the FIFO on that same edge, and the byte counter increments.
  - When the byte counter reaches length-1 and a byte is written, go to DRAIN.
- State DRAIN: din_vld is ignored. When the FIFO becomes empty via a transfer:
  - pulse done in the cycle after that transfer edge;
  - go to IDLE.
- start outside IDLE is ignored.
- FIFO: first-word-fall-through.
  - dout_vld = !empty.
  - dout latency is 1 cycle: a byte completed at edge N is visible with dout_vld=1 after edge N.
  - A simultaneous write and read at full is allowed; the read frees the slot and no overflow occurs.
  - A write at full without a read drops the byte, sets ovf_err, and the byte counter still increments, so block framing is preserved.
- dout and dout_vld hold stable while dout_rdy=0.
- busy = (state != IDLE).
- Reset mid-block discards the FIFO contents and partial byte; no done is generated.

Optional Feature:
- Macro TURBO_RX_BYTE_PACK_FRAME_EN.
- Defined: adds outputs dout_sop (1) and dout_eop (1), stored per FIFO entry alongside the byte.
  - sop = first byte of the block; eop = last byte of the block.
  - Both are qualified by dout_vld and are 0 after reset.
  - The FIFO entry width becomes 10 bits.
- Undefined: the ports are absent and the FIFO is 8 bits wide; all other behaviour is identical.

Test Plan:
- PB16 basic: reset, start with pb_size=0, 64 symbols 0,1,2,3 repeating, dout_rdy=1.
  -> 16 bytes of 0xE4; done pulses once after the 16th transfer; busy drops with done; no errors.
- Latency and packing: single byte from symbols 3,0,0,1.
  -> dout=0x43, with dout_vld rising exactly one cycle after the 4th din_vld edge.
- Backpressure and overflow (FIFO_DEPTH=8, dout_rdy=0, PB16):
  - 9 bytes fed -> FIFO holds 8, ovf_err=1.
  - Release dout_rdy -> 8 bytes out; done after the last transfer, since the dropped byte is counted in the 16.
- Boundary: PB520 with 2080 symbols and random dout_rdy.
  -> exactly 520 transfers, correct data, done once, state IDLE; extra din_vld during DRAIN produces no bytes.
- Error and restart cases:
  - start with pb_size=3 -> size_err=1, busy stays 0.
  - Reset asserted mid-PB136 -> all outputs 0; a following start with PB16 behaves as in the PB16 basic test.
- Frame markers (with macro defined), PB136 -> dout_sop on byte 0 only, dout_eop on byte 135 only.
